// File: rtl/wall_collision_if.sv
// wall_collision_if: frame strobe, tank/wall inputs and committed-move outputs of wall_collision
interface wall_collision_if;
    logic       frame_clk;
    logic [9:0] Tank_X, Tank_Y;
    logic [9:0] Motion_X, Motion_Y;
    logic [9:0] X1, X2, X3, X4;
    logic [9:0] Y1, Y2, Y3, Y4;
    logic [9:0] Next_X, Next_Y;
    logic [3:0] hit_mask;
    logic       blocked;
    logic       done;
    logic       busy;
    logic       overrun;
    modport master (
        output frame_clk, Tank_X, Tank_Y, Motion_X, Motion_Y, X1, X2, X3, X4, Y1, Y2, Y3, Y4,
        input  Next_X, Next_Y, hit_mask, blocked, done, busy, overrun
    );
    modport slave (
        input  frame_clk, Tank_X, Tank_Y, Motion_X, Motion_Y, X1, X2, X3, X4, Y1, Y2, Y3, Y4,
        output Next_X, Next_Y, hit_mask, blocked, done, busy, overrun
    );
endinterface

// File: rtl/wall_collision.sv
// wall_collision: per-frame tank move proposal, screen clamp and sequential four-wall overlap test
module wall_collision #(
    parameter logic [9:0] Tank_Size = 10'd31,
    parameter logic [9:0] Hor_W     = 10'd64,
    parameter logic [9:0] Hor_H     = 10'd32,
    parameter logic [9:0] Vert_W    = 10'd32,
    parameter logic [9:0] Vert_H    = 10'd64,
    parameter logic [9:0] X_Max     = 10'd639,
    parameter logic [9:0] Y_Max     = 10'd479,
    parameter logic [9:0] Init_X    = 10'd300,
    parameter logic [9:0] Init_Y    = 10'd20
) (
    input logic             Clk,
    input logic             Reset,
    wall_collision_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, CHK, COMMIT} state_t;
    localparam logic [11:0] X_Lim = {2'b00, X_Max - Tank_Size};
    localparam logic [11:0] Y_Lim = {2'b00, Y_Max - Tank_Size};
    state_t            r_state, w_next;
    logic [2:0]        r_sync;
    logic [1:0]        r_idx;
    logic [9:0]        r_px, r_py, r_fx, r_fy;
    logic [2:0]        r_acc;
    logic [9:0]        r_next_x, r_next_y;
    logic [3:0]        r_mask;
    logic              r_blocked, r_done, r_overrun;
    logic              w_frame_evt, w_last;
    logic signed [11:0] w_px, w_py;
    logic [9:0]        w_cx, w_cy, w_wx, w_wy, w_w, w_h;
    logic              w_hit;
    logic [3:0]        w_mask;

    assign w_frame_evt = r_sync[1] & ~r_sync[2];
    assign w_last      = (r_state == CHK) && (r_idx == 2'd3);
    assign w_px = $signed({2'b00, bus.Tank_X}) + $signed({{2{bus.Motion_X[9]}}, bus.Motion_X});
    assign w_py = $signed({2'b00, bus.Tank_Y}) + $signed({{2{bus.Motion_Y[9]}}, bus.Motion_Y});
    assign w_cx = w_px[11] ? 10'd0 : (w_px > X_Lim) ? X_Lim[9:0] : w_px[9:0];
    assign w_cy = w_py[11] ? 10'd0 : (w_py > Y_Lim) ? Y_Lim[9:0] : w_py[9:0];
    assign w_wx = (r_idx == 2'd0) ? bus.X1 : (r_idx == 2'd1) ? bus.X2 : (r_idx == 2'd2) ? bus.X3 : bus.X4;
    assign w_wy = (r_idx == 2'd0) ? bus.Y1 : (r_idx == 2'd1) ? bus.Y2 : (r_idx == 2'd2) ? bus.Y3 : bus.Y4;
    assign w_w  = r_idx[0] ? Vert_W : Hor_W;
    assign w_h  = r_idx[0] ? Vert_H : Hor_H;
    assign w_hit = ({1'b0, r_px} <= {1'b0, w_wx} + {1'b0, w_w}) &&
                   ({1'b0, w_wx} <= {1'b0, r_px} + {1'b0, Tank_Size}) &&
                   ({1'b0, r_py} <= {1'b0, w_wy} + {1'b0, w_h}) &&
                   ({1'b0, w_wy} <= {1'b0, r_py} + {1'b0, Tank_Size});
    assign w_mask = {w_hit, r_acc};

    assign bus.Next_X   = r_next_x;
    assign bus.Next_Y   = r_next_y;
    assign bus.hit_mask = r_mask;
    assign bus.blocked  = r_blocked;
    assign bus.done     = r_done;
    assign bus.busy     = (r_state != IDLE);
    assign bus.overrun  = r_overrun;

    // synchronize the frame strobe and keep one extra flop for rising-edge detection
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) r_sync <= 3'b000;
        else        r_sync <= {r_sync[1:0], bus.frame_clk};
    end

    // state register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next state: a frame event only starts a move from IDLE
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE && w_frame_evt) ? LOAD :
                 (r_state == LOAD)                ? CHK :
                 w_last                           ? COMMIT :
                 (r_state == COMMIT)              ? IDLE : r_state;
    end

    // latch proposal and fallback, walk the walls and commit the result
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_idx     <= 2'd0;
            r_px      <= 10'd0;
            r_py      <= 10'd0;
            r_fx      <= 10'd0;
            r_fy      <= 10'd0;
            r_acc     <= 3'd0;
            r_next_x  <= Init_X;
            r_next_y  <= Init_Y;
            r_mask    <= 4'd0;
            r_blocked <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_idx     <= (r_state == CHK) ? r_idx + 2'd1 : 2'd0;
            r_done    <= w_last;
            r_overrun <= r_overrun | (w_frame_evt && r_state != IDLE);
            if (r_state == LOAD) begin
                r_px  <= w_cx;
                r_py  <= w_cy;
                r_fx  <= bus.Tank_X;
                r_fy  <= bus.Tank_Y;
                r_acc <= 3'd0;
            end
            if (r_state == CHK && !w_last) r_acc <= {w_hit, r_acc[2:1]};
            if (w_last) begin
                r_mask    <= w_mask;
                r_blocked <= |w_mask;
                r_next_x  <= (|w_mask) ? r_fx : r_px;
                r_next_y  <= (|w_mask) ? r_fy : r_py;
            end
        end
    end
endmodule

// File: doc/wall_collision.md
WALL_COLLISION -- requirements
Module: wall_collision

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- Tank_Size, 10'd31: tank extent offset; tank occupies [X, X+Tank_Size] inclusive in each axis.
- Hor_W, 10'd64 / Hor_H, 10'd32: dimensions of horizontal walls 1 and 3.
- Vert_W, 10'd32 / Vert_H, 10'd64: dimensions of vertical walls 2 and 4.
- X_Max, 10'd639 / Y_Max, 10'd479: screen limits.
- Init_X, 10'd300 / Init_Y, 10'd20: reset position.
REQ-002 Ports (name, direction, width, meaning), one per line:
- Clk  in  1  50 MHz clock, the single clock of the block.
- Reset  in  1  asynchronous, active-low reset.
- frame_clk  in  1  frame strobe (~60 Hz), asynchronous to Clk.
- Tank_X, Tank_Y  in  10  current tank top-left position.
- Motion_X, Motion_Y  in  10  requested per-frame step, two's complement.
- X1..X4, Y1..Y4  in  10  wall top-left corners, constant between frames.
- Next_X, Next_Y  out  10  committed tank position (registered).
- hit_mask  out  4  bit i-1 set when wall i overlaps the proposed position.
- blocked  out  1  last move rejected.
- done  out  1  one-cycle pulse when a result is committed.
- busy  out  1  high from LOAD through COMMIT.
- overrun  out  1  sticky flag: a frame edge arrived while busy.

Function
REQ-003 frame_clk SHALL pass through a 2-flop synchronizer; a rising edge SHALL be detected with a third flop, producing a one-cycle frame_evt.
REQ-004 FSM states SHALL be IDLE, LOAD, CHK (4 cycles, index 0..3), COMMIT; the only transitions SHALL be IDLE->LOAD on frame_evt, LOAD->CHK, CHK(3)->COMMIT, COMMIT->IDLE.
REQ-005 LOAD SHALL latch PX = Tank_X + sext(Motion_X) and PY = Tank_Y + sext(Motion_Y) in 12-bit signed arithmetic, and SHALL latch Tank_X and Tank_Y as the fallback position.
REQ-006 LOAD clamp: PX<0 -> 0; PX>X_Max-Tank_Size -> X_Max-Tank_Size; same rule in Y with Y_Max.
REQ-007 CHK(i) SHALL evaluate exactly one wall per cycle.
- Walls 1 and 3 use Hor_W/Hor_H; walls 2 and 4 use Vert_W/Vert_H.
- Wall extent is inclusive: [Xi, Xi+W] x [Yi, Yi+H].
REQ-008 Overlap SHALL be PX<=Xi+W && Xi<=PX+Tank_Size && PY<=Yi+H && Yi<=PY+Tank_Size, computed in 11-bit unsigned so no sum wraps; touching edges count as overlap.
REQ-009 In COMMIT, hit_mask SHALL update to the four accumulated results.
- Any bit set: Next = latched Tank_X/Tank_Y, blocked=1.
- Otherwise: Next = clamped PX/PY, blocked=0.
- done=1 for exactly this cycle.
REQ-010 Latency: done SHALL assert 6 Clk cycles after the cycle frame_evt is high (LOAD +1, CHK +2..+5, COMMIT +6).
REQ-011 busy SHALL be 1 in LOAD, CHK and COMMIT, and 0 in IDLE.
REQ-012 A frame_evt while busy SHALL be dropped, SHALL set overrun, and SHALL NOT alter the in-flight computation.
REQ-013 frame_evt in the COMMIT cycle SHALL also count as an overrun; the next move starts only on a later frame_evt seen in IDLE.
REQ-014 Input changes during CHK SHALL NOT affect the result except Xi/Yi of walls not yet evaluated (walls are required static).

Reset
REQ-015 Reset low SHALL immediately force IDLE, Next_X=Init_X, Next_Y=Init_Y, hit_mask=0, blocked=0, done=0, busy=0, overrun=0, and clear the synchronizer flops.
REQ-016 Reset asserted mid-CHK SHALL abandon the move with no done pulse; operation SHALL resume on the first frame_evt after release.

Verification
REQ-017 Reset pulse -> Next=(300,20); hit_mask, blocked, done, busy and overrun all 0.
REQ-018 Walls (50,100),(400,200),(320,240),(600,400); Tank (200,20), Motion (+1,0), one frame edge -> done 6 cycles after frame_evt; Next=(201,20); blocked=0; hit_mask=0000.
REQ-019 Same walls; Tank (18,100), Motion (+1,0) -> proposed extent X [19,50] touches wall 1 at X=50 -> hit_mask=0001, blocked=1, Next=(18,100).
REQ-020 Clamp checks:
- Tank (2,300), Motion_X=10'h3FC (-4) -> Next_X=0.
- Tank (607,0), Motion_X=+5 -> Next_X=608.
- Both cases: blocked=0.
REQ-021 Second frame edge 3 cycles after the first -> overrun=1 and stays 1 until reset; the first result is unchanged; exactly one done pulse.
REQ-022 Reset asserted during CHK(2) -> outputs return to reset values at once; no done pulse; the next frame edge after release completes normally.
